// File: rtl/fpu_pack_sched_pkg.sv
// Shared FPU definitions: widths, class codes, canonical NaN and unit indices,
// plus the class-code to packer-flag decode.
package fpu_pack_sched_pkg;

  localparam int NUM_REQ     = 3;
  localparam int FP_BITS     = 32;
  localparam int RECEXP_BITS = 9;
  localparam int SIG_BITS    = 32;
  localparam int TAG_BITS    = 5;
  localparam int SHIFT_BITS  = 9;
  localparam int IDX_BITS    = 2;

  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_ZERO = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  localparam logic [SIG_BITS-1:0] CANON_NAN_SIG = 32'hC000_0000;

  localparam logic [IDX_BITS-1:0] UNIT_ADD = 2'd0;
  localparam logic [IDX_BITS-1:0] UNIT_MUL = 2'd1;
  localparam logic [IDX_BITS-1:0] UNIT_DIV = 2'd2;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_norm;
    logic is_unorm;
  } cls_flags_t;

  // Illegal codes fall into the NaN flag so the packer always sees exactly one flag.
  function automatic cls_flags_t cls_decode(input logic [2:0] cls);
    cls_flags_t f;
    f = '0;
    case (cls)
      CLS_NORM: f.is_norm  = 1'b1;
      CLS_SUB:  f.is_unorm = 1'b1;
      CLS_ZERO: f.is_zero  = 1'b1;
      CLS_INF:  f.is_inf   = 1'b1;
      CLS_NAN:  f.is_nan   = 1'b1;
      default:  f.is_nan   = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic cls_legal(input logic [2:0] cls);
    return (cls <= CLS_NAN);
  endfunction

endpackage

// File: rtl/fpu_pack_sched_if.sv
// Bundle between the execution units, the shared packer and the writeback port.
interface fpu_pack_sched_if;
  import fpu_pack_sched_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_sign;
  logic [NUM_REQ*RECEXP_BITS-1:0] req_exp;
  logic [NUM_REQ*SIG_BITS-1:0]    req_sig;
  logic [NUM_REQ*3-1:0]           req_cls;
  logic [NUM_REQ*SHIFT_BITS-1:0]  req_shift;
  logic [NUM_REQ*TAG_BITS-1:0]    req_tag;
  logic                           flush;

  logic                   pk_sign;
  logic [RECEXP_BITS-1:0] pk_exp;
  logic [SIG_BITS-1:0]    pk_sig;
  logic [SHIFT_BITS-1:0]  pk_shift;
  logic                   pk_isNAN;
  logic                   pk_isINf;
  logic                   pk_isZero;
  logic                   pk_isNormalize;
  logic                   pk_isUnormalize;
  logic [FP_BITS-1:0]     pk_fp;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [FP_BITS-1:0]     wb_data;
  logic [TAG_BITS-1:0]    wb_tag;
  logic [1:0]             wb_src;
  logic                   busy;

  modport slave (
    input  req_valid, req_sign, req_exp, req_sig, req_cls, req_shift, req_tag, flush,
    input  pk_fp, wb_ready,
    output req_ready, pk_sign, pk_exp, pk_sig, pk_shift,
    output pk_isNAN, pk_isINf, pk_isZero, pk_isNormalize, pk_isUnormalize,
    output wb_valid, wb_data, wb_tag, wb_src, busy
  );

  modport master (
    output req_valid, req_sign, req_exp, req_sig, req_cls, req_shift, req_tag, flush,
    output pk_fp, wb_ready,
    input  req_ready, pk_sign, pk_exp, pk_sig, pk_shift,
    input  pk_isNAN, pk_isINf, pk_isZero, pk_isNormalize, pk_isUnormalize,
    input  wb_valid, wb_data, wb_tag, wb_src, busy
  );

endinterface

// File: rtl/fpu_pack_sched_rr_pick.sv
// Combinational round-robin picker: first valid requester after 'last', one-hot grant.
module fpu_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o
);

  logic found;
  logic hit;

  // Walk offsets last+1 .. last+N; the first valid unit met takes the grant.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    hit     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        hit        = en_i & ~found & valid_i[i] & (((int'(last_i) + k) % N) == i);
        grant_o[i] = grant_o[i] | hit;
        found      = found | hit;
      end
    end
  end

endmodule

// File: rtl/fpu_pack_sched.sv
// Round-robin scheduler sharing one result packer among the add/mul/div units.
// S1 registers the winner's operands for the packer; S2 holds the packed word for writeback.
module fpu_pack_sched
  import fpu_pack_sched_pkg::*;
(
  input logic             clk,
  input logic             rst,
  fpu_pack_sched_if.slave bus
);

  logic [NUM_REQ-1:0]     grant_s;
  logic [IDX_BITS-1:0]    gidx_s;
  logic                   sel_sign_s;
  logic [RECEXP_BITS-1:0] sel_exp_s;
  logic [SIG_BITS-1:0]    sel_sig_s;
  logic [2:0]             sel_cls_s;
  logic [SHIFT_BITS-1:0]  sel_shift_s;
  logic [TAG_BITS-1:0]    sel_tag_s;
  logic                   s2_adv_s, s1_adv_s, pick_en_s, xfer_s;

  logic                   s1_valid_q, s1_valid_d, wb_valid_q, wb_valid_d;
  logic [IDX_BITS-1:0]    last_q, last_d, s1_src_q, s1_src_d, wb_src_q, wb_src_d;
  logic [TAG_BITS-1:0]    s1_tag_q, s1_tag_d, wb_tag_q, wb_tag_d;
  logic                   pk_sign_q, pk_sign_d;
  logic [RECEXP_BITS-1:0] pk_exp_q, pk_exp_d;
  logic [SIG_BITS-1:0]    pk_sig_q, pk_sig_d;
  logic [SHIFT_BITS-1:0]  pk_shift_q, pk_shift_d;
  cls_flags_t             flags_q, flags_d;
  logic [FP_BITS-1:0]     wb_data_q, wb_data_d;

  assign s2_adv_s  = ~wb_valid_q | bus.wb_ready;
  assign s1_adv_s  = ~s1_valid_q | s2_adv_s;
  // Flush and reset must block acceptance in the very cycle they are asserted.
  assign pick_en_s = s1_adv_s & ~bus.flush & ~rst;

  fpu_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_BITS)) u_pick (
    .valid_i (bus.req_valid),
    .last_i  (last_q),
    .en_i    (pick_en_s),
    .grant_o (grant_s)
  );

  assign bus.req_ready = grant_s;
  assign xfer_s        = |(grant_s & bus.req_valid);

  // AND-OR operand mux steered by the one-hot grant.
  always_comb begin
    gidx_s      = '0;
    sel_sign_s  = 1'b0;
    sel_exp_s   = '0;
    sel_sig_s   = '0;
    sel_cls_s   = '0;
    sel_shift_s = '0;
    sel_tag_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s      = gidx_s | (IDX_BITS'(i) & {IDX_BITS{grant_s[i]}});
      sel_sign_s  = sel_sign_s | (bus.req_sign[i] & grant_s[i]);
      sel_exp_s   = sel_exp_s | (bus.req_exp[i*RECEXP_BITS +: RECEXP_BITS] & {RECEXP_BITS{grant_s[i]}});
      sel_sig_s   = sel_sig_s | (bus.req_sig[i*SIG_BITS +: SIG_BITS] & {SIG_BITS{grant_s[i]}});
      sel_cls_s   = sel_cls_s | (bus.req_cls[i*3 +: 3] & {3{grant_s[i]}});
      sel_shift_s = sel_shift_s | (bus.req_shift[i*SHIFT_BITS +: SHIFT_BITS] & {SHIFT_BITS{grant_s[i]}});
      sel_tag_s   = sel_tag_s | (bus.req_tag[i*TAG_BITS +: TAG_BITS] & {TAG_BITS{grant_s[i]}});
    end
  end

  // Pipeline next state; flush drops both stages but keeps the round-robin pointer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    wb_valid_d = wb_valid_q;
    last_d     = last_q;
    s1_src_d   = s1_src_q;
    s1_tag_d   = s1_tag_q;
    pk_sign_d  = pk_sign_q;
    pk_exp_d   = pk_exp_q;
    pk_sig_d   = pk_sig_q;
    pk_shift_d = pk_shift_q;
    flags_d    = flags_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    wb_src_d   = wb_src_q;
    if (bus.flush) begin
      s1_valid_d = 1'b0;
      wb_valid_d = 1'b0;
    end else begin
      if (s2_adv_s) begin
        wb_valid_d = s1_valid_q;
        wb_data_d  = bus.pk_fp;
        wb_tag_d   = s1_tag_q;
        wb_src_d   = s1_src_q;
      end else begin
        wb_valid_d = wb_valid_q;
      end
      if (s1_adv_s) begin
        s1_valid_d = xfer_s;
        if (xfer_s) begin
          last_d     = gidx_s;
          s1_src_d   = gidx_s;
          s1_tag_d   = sel_tag_s;
          pk_sign_d  = sel_sign_s;
          pk_exp_d   = sel_exp_s;
          pk_sig_d   = cls_legal(sel_cls_s) ? sel_sig_s : CANON_NAN_SIG;
          pk_shift_d = sel_shift_s;
          flags_d    = cls_decode(sel_cls_s);
        end else begin
          last_d = last_q;
        end
      end else begin
        s1_valid_d = s1_valid_q;
      end
    end
  end

  // State registers with synchronous reset; unit 0 gets first priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      last_q     <= IDX_BITS'(NUM_REQ - 1);
      s1_src_q   <= '0;
      s1_tag_q   <= '0;
      pk_sign_q  <= 1'b0;
      pk_exp_q   <= '0;
      pk_sig_q   <= '0;
      pk_shift_q <= '0;
      flags_q    <= '0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_src_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      wb_valid_q <= wb_valid_d;
      last_q     <= last_d;
      s1_src_q   <= s1_src_d;
      s1_tag_q   <= s1_tag_d;
      pk_sign_q  <= pk_sign_d;
      pk_exp_q   <= pk_exp_d;
      pk_sig_q   <= pk_sig_d;
      pk_shift_q <= pk_shift_d;
      flags_q    <= flags_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign bus.pk_sign         = pk_sign_q;
  assign bus.pk_exp          = pk_exp_q;
  assign bus.pk_sig          = pk_sig_q;
  assign bus.pk_shift        = pk_shift_q;
  assign bus.pk_isNAN        = flags_q.is_nan;
  assign bus.pk_isINf        = flags_q.is_inf;
  assign bus.pk_isZero       = flags_q.is_zero;
  assign bus.pk_isNormalize  = flags_q.is_norm;
  assign bus.pk_isUnormalize = flags_q.is_unorm;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.wb_tag          = wb_tag_q;
  assign bus.wb_src          = wb_src_q;
  assign bus.busy            = s1_valid_q | wb_valid_q;

endmodule

// File: tb/tb_fpu_pack_sched.sv
// Scoreboard bench for fpu_pack_sched: directed scenarios plus random traffic,
// with a simple packer model on pk_* and a reference model predicting grants and words.
module tb_fpu_pack_sched;
  import fpu_pack_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_pack_sched_if bif ();
  fpu_pack_sched dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic [1:0]  src;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_log[$];
  logic [31:0] out_log[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          model_last = NUM_REQ - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Packer stand-in: recoded exponent bias is 257, hidden bit dropped, truncating.
  logic [31:0] pk_m;
  logic [8:0]  pk_be;
  always_comb begin
    pk_m  = bif.pk_sig >> bif.pk_shift;
    pk_be = bif.pk_exp - 9'd257;
    if (bif.pk_isNAN)            bif.pk_fp = {bif.pk_sign, 8'hFF, bif.pk_sig[30:8]};
    else if (bif.pk_isINf)       bif.pk_fp = {bif.pk_sign, 8'hFF, 23'd0};
    else if (bif.pk_isZero)      bif.pk_fp = {bif.pk_sign, 31'd0};
    else if (bif.pk_isUnormalize) bif.pk_fp = {bif.pk_sign, 8'h00, pk_m[30:8]};
    else if (bif.pk_isNormalize) bif.pk_fp = {bif.pk_sign, pk_be[7:0], bif.pk_sig[30:8]};
    else                         bif.pk_fp = 32'd0;
  end

  // Expected IEEE word straight from a unit's raw fields.
  function automatic logic [31:0] ref_word(input logic s, input logic [8:0] e, input logic [31:0] sg,
                                           input logic [2:0] c, input logic [8:0] sh);
    logic [31:0] m;
    logic [8:0]  be;
    m  = sg >> sh;
    be = e - 9'd257;
    case (c)
      3'd0:    return {s, be[7:0], sg[30:8]};
      3'd1:    return {s, 8'h00, m[30:8]};
      3'd2:    return {s, 31'd0};
      3'd3:    return {s, 8'hFF, 23'd0};
      3'd4:    return {s, 8'hFF, sg[30:8]};
      default: return {s, 8'hFF, 23'h40_0000};
    endcase
  endfunction

  function automatic int rr_model(input logic [2:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // Monitor: legality checks, scoreboard push on accept, pop on writeback.
  logic        hold_q = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_tag;
  logic [1:0]  hold_src;
  always @(negedge clk) begin
    exp_t e;
    int   w;
    logic [2:0] acc;
    chk("ready_onehot0", $onehot0(bif.req_ready), 1'b1);
    chk("ready_needs_valid", bif.req_ready & ~bif.req_valid, 3'd0);
    chk("busy", bif.busy, sb_q.size() != 0);
    if (rst || bif.flush) chk("ready_gated", bif.req_ready, 3'd0);
    if (hold_q) begin
      chk("hold_valid", bif.wb_valid, 1'b1);
      chk("hold_data", bif.wb_data, hold_data);
      chk("hold_tag", bif.wb_tag, hold_tag);
      chk("hold_src", bif.wb_src, hold_src);
    end
    hold_q    = bif.wb_valid && !bif.wb_ready && !rst && !bif.flush;
    hold_data = bif.wb_data;
    hold_tag  = bif.wb_tag;
    hold_src  = bif.wb_src;
    if (bif.wb_valid && bif.wb_ready) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_data", bif.wb_data, e.data);
        chk("wb_tag", bif.wb_tag, e.tag);
        chk("wb_src", bif.wb_src, e.src);
        out_log.push_back(bif.wb_data);
      end
    end
    acc = bif.req_valid & bif.req_ready;
    if (rst) begin
      sb_q.delete();
      model_last = NUM_REQ - 1;
    end else if (bif.flush) begin
      sb_q.delete();
    end else if (acc != 3'd0) begin
      w = rr_model(bif.req_valid, model_last);
      chk("grant", acc, 64'd1 << w);
      e.data = ref_word(bif.req_sign[w], bif.req_exp[w*9 +: 9], bif.req_sig[w*32 +: 32],
                        bif.req_cls[w*3 +: 3], bif.req_shift[w*9 +: 9]);
      e.tag  = bif.req_tag[w*5 +: 5];
      e.src  = 2'(w);
      sb_q.push_back(e);
      acc_log.push_back(w);
      model_last = w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic s, input logic [8:0] e, input logic [31:0] sg,
                          input logic [2:0] c, input logic [8:0] sh, input logic [4:0] t);
    bif.req_sign[u]         = s;
    bif.req_exp[u*9 +: 9]   = e;
    bif.req_sig[u*32 +: 32] = sg;
    bif.req_cls[u*3 +: 3]   = c;
    bif.req_shift[u*9 +: 9] = sh;
    bif.req_tag[u*5 +: 5]   = t;
  endtask

  task automatic rand_payload();
    for (int u = 0; u < NUM_REQ; u++)
      set_unit(u, 1'($urandom), 9'($urandom), 32'($urandom) | 32'h8000_0000,
               3'($urandom_range(0, 7)), 9'($urandom_range(0, 40)), 5'($urandom));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bif.busy) && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, n < 20, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wb_valid"}, bif.wb_valid, 1'b0);
    chk({name, "_busy"}, bif.busy, 1'b0);
    chk({name, "_pk_ops"}, {bif.pk_sign, bif.pk_exp, bif.pk_sig, bif.pk_shift}, 64'd0);
    chk({name, "_pk_flags"}, {bif.pk_isNAN, bif.pk_isINf, bif.pk_isZero, bif.pk_isNormalize,
                              bif.pk_isUnormalize}, 5'd0);
    chk({name, "_wb_payload"}, {bif.wb_data, bif.wb_tag, bif.wb_src}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_acc, b_out;
    rst           = 1'b1;
    bif.flush     = 1'b0;
    bif.wb_ready  = 1'b1;
    bif.req_valid = 3'd0;
    rand_payload();
    tick();
    tick();
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Single normal result from the add unit.
    set_unit(UNIT_ADD, 1'b0, 9'h180, 32'h8000_0000, CLS_NORM, 9'd0, 5'd3);
    bif.req_valid = 3'b001;
    @(negedge clk);
    chk("t1_ready", bif.req_ready, 3'b001);
    tick();
    bif.req_valid = 3'd0;
    @(negedge clk);
    chk("t1_lat_n1", bif.wb_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_lat_n2", bif.wb_valid, 1'b1);
    chk("t1_data", bif.wb_data, 32'h3F80_0000);
    chk("t1_tag", bif.wb_tag, 5'd3);
    chk("t1_src", bif.wb_src, 2'd0);
    tick();

    // Fairness and full throughput from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_acc = acc_log.size();
    bif.req_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      rand_payload();
      @(negedge clk);
      chk("fair_ready", |bif.req_ready, 1'b1);
      if (j >= 2) chk("fair_thru", bif.wb_valid, 1'b1);
      tick();
    end
    bif.req_valid = 3'd0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("fair_tail", bif.wb_valid, 1'b1);
      tick();
    end
    chk("fair_count", acc_log.size() - b_acc, 6);
    for (int k = 0; k < 6; k++) chk("fair_order", acc_log[b_acc + k], k % 3);

    // Backpressure with the mul unit streaming.
    drain("pre_bp");
    b_acc = acc_log.size();
    b_out = out_log.size();
    bif.wb_ready  = 1'b0;
    bif.req_valid = 3'b010;
    for (int j = 0; j < 5; j++) begin
      rand_payload();
      @(negedge clk);
      chk("bp_ready", bif.req_ready, (j < 2) ? 3'b010 : 3'b000);
      tick();
    end
    chk("bp_buffered", acc_log.size() - b_acc, 2);
    bif.req_valid = 3'd0;
    bif.wb_ready  = 1'b1;
    drain("bp");
    chk("bp_drained", out_log.size() - b_out, 2);

    // Class mapping: signed zero, infinity, illegal code.
    b_out = out_log.size();
    bif.req_valid = 3'b001;
    set_unit(0, 1'b1, 9'($urandom), 32'($urandom), CLS_ZERO, 9'd0, 5'd1);
    tick();
    set_unit(0, 1'b0, 9'($urandom), 32'($urandom), CLS_INF, 9'd0, 5'd2);
    tick();
    set_unit(0, 1'b0, 9'($urandom), 32'($urandom), 3'd6, 9'd0, 5'd3);
    tick();
    bif.req_valid = 3'd0;
    drain("cls");
    chk("cls_count", out_log.size() - b_out, 3);
    if (out_log.size() - b_out == 3) begin
      chk("cls_zero", out_log[b_out], 32'h8000_0000);
      chk("cls_inf", out_log[b_out + 1], 32'h7F80_0000);
      chk("cls_illegal", out_log[b_out + 2], 32'h7FC0_0000);
    end

    // Flush with both stages full and the div unit requesting.
    b_out = out_log.size();
    bif.wb_ready  = 1'b0;
    bif.req_valid = 3'b001;
    rand_payload();
    tick();
    rand_payload();
    tick();
    bif.req_valid = 3'b100;
    bif.flush     = 1'b1;
    @(negedge clk);
    chk("flush_ready", bif.req_ready, 3'b000);
    chk("flush_busy_before", bif.busy, 1'b1);
    tick();
    bif.flush     = 1'b0;
    bif.req_valid = 3'd0;
    bif.wb_ready  = 1'b1;
    @(negedge clk);
    chk("flush_busy_after", bif.busy, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("flush_no_wb", bif.wb_valid, 1'b0);
      tick();
    end
    chk("flush_dropped", out_log.size() - b_out, 0);

    // Reset in the middle of full throughput.
    bif.req_valid = 3'b111;
    for (int j = 0; j < 5; j++) begin
      rand_payload();
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bif.req_ready, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    chk("midrst_first_grant", bif.req_ready, 3'b001);
    tick();

    // Random traffic with stalls, occasional flushes and resets.
    for (int j = 0; j < 400; j++) begin
      bif.req_valid = 3'($urandom);
      bif.wb_ready  = ($urandom_range(0, 9) < 7);
      bif.flush     = ($urandom_range(0, 49) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      rand_payload();
      tick();
    end
    bif.req_valid = 3'd0;
    bif.flush     = 1'b0;
    bif.wb_ready  = 1'b1;
    rst           = 1'b0;
    drain("final");
    chk("final_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_pack_sched.md
# fpu_pack_sched

Round-robin scheduler that shares the single result packer between the FPU's execution units (add, mul, div/sqrt). Each unit presents an unpacked result: sign, recoded exponent, significand, class code, subnormal shift and destination tag. The block arbitrates among the units and registers the winner into an issue stage that drives the packer's inputs. It then captures the packer's standard-format word into a writeback stage with a valid/ready handshake. It sits between the execution units and the register-file writeback port.

## Interface
- `NUM_REQ`, 3, number of requesting units; index 0 = add, 1 = mul, 2 = div.
- `FP_BITS`, 32, packed result width.
- `RECEXP_BITS`, 9, recoded exponent width.
- `SIG_BITS`, 32, significand width; hidden bit at bit SIG_BITS-1.
- `TAG_BITS`, 5, destination-register tag width.

- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-unit result valid.
- `req_ready` out NUM_REQ: per-unit accept; one-hot or zero.
- `req_sign` in NUM_REQ: sign per unit.
- `req_exp` in NUM_REQ*RECEXP_BITS: recoded exponent; unit i occupies slice [i*RECEXP_BITS +: RECEXP_BITS].
- `req_sig` in NUM_REQ*SIG_BITS: significand, same slicing rule.
- `req_cls` in NUM_REQ*3: class code. 0 = normal, 1 = subnormal, 2 = zero, 3 = inf, 4 = NaN, 5–7 = illegal.
- `req_shift` in NUM_REQ*9: subnormal right-shift amount.
- `req_tag` in NUM_REQ*TAG_BITS: destination tag.
- `flush` in 1: discard all in-flight results.
- `pk_sign` out 1, `pk_exp` out RECEXP_BITS, `pk_sig` out SIG_BITS, `pk_shift` out 9: packer operands, registered.
- `pk_isNAN`, `pk_isINf`, `pk_isZero`, `pk_isNormalize`, `pk_isUnormalize` out 1 each: one-hot class flags to the packer, registered.
- `pk_fp` in FP_BITS: packer result, combinational from the `pk_*` outputs.
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake.
- `wb_data` out FP_BITS, `wb_tag` out TAG_BITS, `wb_src` out 2: writeback payload; `wb_src` is the winning unit index.
- `busy` out 1: high when either stage holds a valid result.

## Operation
- Two pipeline stages: S1 (issue register, drives `pk_*`) and S2 (writeback register, captures `pk_fp`).
- Stage advance conditions:
  - `s2_adv = !wb_valid | wb_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
- Arbitration:
  - Round-robin pointer `last` holds the index of the most recently granted unit.
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - The first valid unit in that order wins.
  - A grant is issued only when `s1_adv` is high. `req_ready[i] = grant[i]`, so ready may depend on valid.
  - A transfer occurs when `req_valid[i] & req_ready[i]`. On a transfer, `last <= i` and S1 loads that unit's operands.
- Class decode at S1 load:
  - Codes 0–4 map to exactly one `pk_is*` flag.
  - Illegal codes 5–7 set `pk_isNAN` and force `pk_sig` to 0xC0000000 (canonical quiet NaN).
- `pk_shift` passes through unchanged. The packer defines its meaning and ignores it unless the class is subnormal.
- When S2 advances, S2 loads `pk_fp`, the S1 tag and the S1 source, with `wb_valid <= s1_valid`.
- When S1 advances with no grant, `s1_valid <= 0`.
- `flush`:
  - Clears `s1_valid` and `wb_valid` next cycle.
  - Forces `req_ready` to 0 in the same cycle, so nothing is accepted.
  - Leaves `last` unchanged.
- `busy = s1_valid | wb_valid`.

## Timing
- Latency: an accept in cycle N gives `wb_valid` high in cycle N+2 when unstalled.
- Throughput: one result per cycle with `wb_ready` held high.
- With `wb_ready` low, S2 holds its contents and S1 holds one more result. After that, `req_ready` is all zero. No result is lost or duplicated.
- Reset values:
  - `s1_valid`, `wb_valid` = 0.
  - `last` = NUM_REQ-1, so unit 0 has first priority.
  - All `pk_*`, `wb_data`, `wb_tag`, `wb_src` = 0.
  - `req_ready` = 0 during the reset cycle.
- Simultaneous events:
  - `flush` overrides any accept or advance in the same cycle.
  - `rst` overrides `flush`.
  - Reset in mid-operation drops every in-flight result.
- `wb_*` payload stays stable while `wb_valid & !wb_ready`.

## Structure
- Shared FPU package holds:
  - Class-code constants (`CLS_NORM` … `CLS_NAN`).
  - Canonical NaN significand.
  - Unit-index constants.
- Sub-module `fpu_rr_pick`: combinational round-robin picker with inputs `valid`, `last`, `en` and output one-hot `grant`. It is reused by other FPU sharing points.
- The packer is instantiated outside this block and connected only through the `pk_*`/`pk_fp` ports.

## Test plan
- Single result, packer connected: unit 0 sends exp 9'h180, sig 0x80000000, cls 0, tag 3. Expected: `wb_valid` two cycles later, `wb_data` 0x3F800000, `wb_tag` 3, `wb_src` 0.
- Fairness: all three units hold `req_valid` high for 6 beats with `wb_ready`=1. Expected grant order 0,1,2,0,1,2 and one result per cycle after fill.
- Backpressure: `wb_ready`=0 for 5 cycles with unit 1 streaming. Expected: exactly 2 results buffered, `req_ready` 0 from the third cycle, and results then drain in order with no loss.
- Class mapping: send cls 2 with sign 1, cls 3, and cls 6. Expected `wb_data` 0x80000000, 0x7F800000 and 0x7FC00000 respectively.
- Flush: flush is asserted while S1 and S2 are both valid and unit 2 requests. Expected: `req_ready`=0 that cycle, `busy`=0 the next cycle, and `wb_valid` never asserted for flushed results.
- Reset mid-stream: `rst` is pulsed during full throughput. Expected: all outputs at reset values next cycle, and the first post-reset grant goes to unit 0.
